// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM bus arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_e;

   localparam logic M0_ID = 1'b0;
   localparam logic M1_ID = 1'b1;

   localparam int unsigned STARVE_MAX_DEFAULT = 8;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Request/grant/read-valid handshake between one bus master and the arbiter.
interface dmem_bus_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;

   modport master (output req, we, addr, wdata, input gnt, rvalid);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles M1 has been left waiting.
module arb_starve_counter #(
   parameter int unsigned MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat_c
);
   localparam int unsigned CNT_W = $clog2(MAX + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && !sat_c) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign sat_c = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the single-port data RAM: M0 has priority, M1 is
// forced through after STARVE_MAX blocked cycles; reads take one extra cycle.
module dmem_bus_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   dmem_bus_arbiter_if.slave     m0,
   dmem_bus_arbiter_if.slave     m1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   arb_state_e            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  m1_sat;
   logic                  win_valid;
   logic                  win_id;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
      .clk   (clk),
      .rst   (rst),
      .inc   (m1.req && !m1.gnt),
      .clr   (!m1.req || m1.gnt),
      .sat_c (m1_sat)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= M0_ID;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Winner select: a starved M1 overrides M0's fixed priority.
   always_comb begin
      win_valid = 1'b0;
      win_id    = M0_ID;
      if (m1.req && m1_sat) begin
         win_valid = 1'b1;
         win_id    = M1_ID;
      end else if (m0.req) begin
         win_valid = 1'b1;
         win_id    = M0_ID;
      end else if (m1.req) begin
         win_valid = 1'b1;
         win_id    = M1_ID;
      end
      win_we    = (win_id == M1_ID) ? m1.we    : m0.we;
      win_addr  = (win_id == M1_ID) ? m1.addr  : m0.addr;
      win_wdata = (win_id == M1_ID) ? m1.wdata : m0.wdata;
   end

   // Zero-cycle grant and RAM drive; everything held at 0 during reset.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      m0.gnt    = 1'b0;
      m1.gnt    = 1'b0;
      m0.rvalid = 1'b0;
      m1.rvalid = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rst) begin
         unique case (state_q)
            IDLE: begin
               if (win_valid) begin
                  m0.gnt   = (win_id == M0_ID);
                  m1.gnt   = (win_id == M1_ID);
                  ram_addr = win_addr;
                  if (win_we) begin
                     ram_we    = 1'b1;
                     ram_wdata = win_wdata;
                  end else begin
                     ram_re  = 1'b1;
                     owner_d = win_id;
                     state_d = RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               m0.rvalid = (owner_q == M0_ID);
               m1.rvalid = (owner_q == M1_ID);
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign rdata = rst ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Randomized and directed bench for dmem_bus_arbiter against a cycle-level
// reference model and a behavioural RAM.
module tb_dmem_bus_arbiter;
   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam int unsigned SMAX = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
   dmem_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_if ();

   logic [DW-1:0] rdata;
   logic          ram_we;
   logic          ram_re;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   dmem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .rdata     (rdata),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Behavioural synchronous RAM, 16 words (address bits [3:0]).
   logic [DW-1:0] ram_mem [16];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_rdata <= '0;
      end else begin
         if (ram_we) ram_mem[ram_addr[3:0]] <= ram_wdata;
         if (ram_re) ram_rdata <= ram_mem[ram_addr[3:0]];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] ref_mem [16];
   bit            pend       = 1'b0;
   bit            pend_owner = 1'b0;
   logic [DW-1:0] pend_data  = '0;
   int            starve     = 0;
   int            m1_wait    = 0;
   int            max_wait   = 0;
   bit            last_g0    = 1'b0;
   bit            last_g1    = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Called at the falling edge: compare outputs, then advance the model one cycle.
   task automatic eval_cycle();
      bit            e_g0 = 0, e_g1 = 0, e_we = 0, e_re = 0, e_rv0 = 0, e_rv1 = 0;
      logic [AW-1:0] e_addr = '0;
      logic [DW-1:0] e_wdata = '0;
      logic [DW-1:0] e_rdata = '0;
      last_g0 = m0_if.gnt;
      last_g1 = m1_if.gnt;
      if (!rst) begin
         check("rst_zero", {m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, ram_we, ram_re}, 0);
         check("rst_addr", ram_addr, 0);
         check("rst_wdata", ram_wdata, 0);
         check("rst_rdata", rdata, 0);
         pend = 0; starve = 0; m1_wait = 0;
         return;
      end
      if (pend) begin
         e_rv0   = (pend_owner == 1'b0);
         e_rv1   = (pend_owner == 1'b1);
         e_rdata = pend_data;
      end else begin
         if (m1_if.req && starve == SMAX) e_g1 = 1;
         else if (m0_if.req)              e_g0 = 1;
         else if (m1_if.req)              e_g1 = 1;
         if (e_g0 || e_g1) begin
            e_addr = e_g1 ? m1_if.addr : m0_if.addr;
            if (e_g1 ? m1_if.we : m0_if.we) begin
               e_we    = 1;
               e_wdata = e_g1 ? m1_if.wdata : m0_if.wdata;
            end else begin
               e_re = 1;
            end
         end
      end
      check("m0_gnt", m0_if.gnt, e_g0);
      check("m1_gnt", m1_if.gnt, e_g1);
      check("ram_we", ram_we, e_we);
      check("ram_re", ram_re, e_re);
      check("m0_rvalid", m0_if.rvalid, e_rv0);
      check("m1_rvalid", m1_if.rvalid, e_rv1);
      if (e_we || e_re) check("ram_addr", ram_addr, e_addr);
      if (e_we) check("ram_wdata", ram_wdata, e_wdata);
      if (e_rv0 || e_rv1) check("rdata", rdata, e_rdata);
      // Advance model
      if (e_we) ref_mem[e_addr[3:0]] = e_wdata;
      pend = e_re;
      if (e_re) begin
         pend_owner = e_g1;
         pend_data  = ref_mem[e_addr[3:0]];
      end
      if (m1_if.req && !e_g1) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else starve = 0;
      // Observed M1 waiting time, from the DUT's own grants
      if (m1_if.gnt) begin
         if (m1_wait > max_wait) max_wait = m1_wait;
         m1_wait = 0;
      end else if (m1_if.req) m1_wait++;
      else m1_wait = 0;
   endtask

   task automatic step();
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
   endtask

   // Masters hold a request until granted, then may issue a new random one.
   task automatic drive_random(input int p0, input int p1, input int pw);
      if (!m0_if.req || last_g0) begin
         m0_if.req   = ($urandom_range(0, 99) < p0);
         m0_if.we    = ($urandom_range(0, 99) < pw);
         m0_if.addr  = AW'($urandom_range(0, 15));
         m0_if.wdata = $urandom;
      end
      if (!m1_if.req || last_g1) begin
         m1_if.req   = ($urandom_range(0, 99) < p1);
         m1_if.we    = ($urandom_range(0, 99) < pw);
         m1_if.addr  = AW'($urandom_range(0, 15));
         m1_if.wdata = $urandom;
      end
   endtask

   // M0 writes every cycle while M1 holds a read; returns cycles until M1 is granted.
   task automatic wait_m1_grant(output int n);
      bit got;
      n = -1;
      m1_if.req = 1; m1_if.we = 0; m1_if.addr = AW'($urandom_range(0, 15));
      for (int i = 1; i <= 20; i++) begin
         m0_if.req = 1; m0_if.we = 1;
         m0_if.addr = AW'($urandom_range(0, 15)); m0_if.wdata = $urandom;
         @(negedge clk);
         got = m1_if.gnt;
         eval_cycle();
         @(posedge clk);
         #1;
         if (got) begin
            n = i;
            break;
         end
      end
      m0_if.req = 0;
      m1_if.req = 0;
   endtask

   initial begin
      int n, g_cnt, m1_grants;
      m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
      m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;

      // Reset with a pending M1 request: all outputs must stay 0
      m1_if.req = 1;
      @(posedge clk); #1;
      step();
      m1_if.req = 0;
      rst = 1'b1;
      step();

      // Back-to-back M0 writes fill the RAM, one grant per cycle
      g_cnt = 0;
      for (int a = 0; a < 16; a++) begin
         m0_if.req = 1; m0_if.we = 1; m0_if.addr = AW'(a); m0_if.wdata = $urandom;
         @(negedge clk);
         g_cnt += int'(m0_if.gnt);
         eval_cycle();
         @(posedge clk); #1;
      end
      m0_if.req = 0;
      check("b2b_writes", 64'(g_cnt), 16);

      // Single M0 write, same-cycle grant
      m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h10; m0_if.wdata = 32'hDEADBEEF;
      @(negedge clk);
      check("t1_m0_gnt", m0_if.gnt, 1);
      check("t1_ram_we", ram_we, 1);
      check("t1_ram_addr", ram_addr, 32'h10);
      eval_cycle();
      @(posedge clk); #1;
      m0_if.req = 0;

      // M1 read of that word: grant at N, rvalid with data at N+1
      m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h10;
      @(negedge clk);
      check("t2_m1_gnt", m1_if.gnt, 1);
      check("t2_ram_re", ram_re, 1);
      eval_cycle();
      @(posedge clk); #1;
      m1_if.req = 0;
      @(negedge clk);
      check("t2_m1_rvalid", m1_if.rvalid, 1);
      check("t2_m0_rvalid", m0_if.rvalid, 0);
      check("t2_rdata", rdata, 32'hDEADBEEF);
      eval_cycle();
      @(posedge clk); #1;

      // Both masters reading continuously: M1 still gets through within bound
      max_wait = 0; m1_wait = 0; m1_grants = 0;
      for (int c = 0; c < 40; c++) begin
         drive_random(100, 100, 0);
         @(negedge clk);
         m1_grants += int'(m1_if.gnt);
         eval_cycle();
         @(posedge clk); #1;
      end
      m0_if.req = 0; m1_if.req = 0;
      step(); step();
      check("t3_m1_grants_ge3", 64'(m1_grants >= 3), 1);
      check("t3_max_wait_le10", 64'(max_wait <= SMAX + 2), 1);

      // Starvation guard under continuous M0 writes
      wait_m1_grant(n);
      check("t6_starve_wait", 64'(n), 64'(SMAX + 1));

      // M1 blocked 5 cycles, drops, reasserts: counter restarts
      for (int c = 0; c < 5; c++) begin
         m0_if.req = 1; m0_if.we = 1; m0_if.addr = AW'(c); m0_if.wdata = $urandom;
         m1_if.req = 1; m1_if.we = 0; m1_if.addr = AW'(c);
         step();
      end
      m1_if.req = 0;
      step();
      wait_m1_grant(n);
      check("t6_restart_wait", 64'(n), 64'(SMAX + 1));

      // Reset during RD_WAIT aborts the read
      for (int c = 0; c < 4; c++) begin
         m0_if.req = 1; m0_if.we = 1; m0_if.addr = AW'(c); m0_if.wdata = $urandom;
         m1_if.req = 1; m1_if.we = 0; m1_if.addr = AW'(3);
         step();
      end
      m0_if.we = 0; m0_if.addr = AW'(5);
      step();
      m0_if.req = 0;
      rst = 1'b0;
      @(negedge clk);
      check("t5_m0_rvalid", m0_if.rvalid, 0);
      check("t5_m1_rvalid", m1_if.rvalid, 0);
      eval_cycle();
      @(posedge clk); #1;
      rst = 1'b1;
      m1_if.req = 0;
      step();
      wait_m1_grant(n);
      check("t5_cnt_cleared", 64'(n), 64'(SMAX + 1));

      // Random traffic
      max_wait = 0; m1_wait = 0;
      for (int c = 0; c < 600; c++) begin
         drive_random(70, 50, 50);
         step();
      end
      check("rand_max_wait_le10", 64'(max_wait <= SMAX + 2), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
